calc_op_sequencer: RTL and testbench

//  Sequences one calculator operation at a time between uartInput (operand/opcode source)
//  and the shared combinational alu, using a request/result valid-ready handshake.

---
 rtl/calc_op_sequencer_if.sv | 44 ++++
 rtl/calc_op_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : calc_op_sequencer_if
//  Description : Request / ALU / result bundle between the operand source, the
//                calculator op sequencer and the shared combinational ALU.
//                The master side is the environment: the operand source, the
//                result consumer and the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface calc_op_sequencer_if #(
    parameter int WIDTH = 16
);
    // Request channel
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_op;
    logic             req_chain;

    // Shared combinational ALU
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;

    // Result channel and status
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic             busy;

    modport master (
        output req_valid, req_a, req_b, req_op, req_chain, res_ready, alu_result,
        input  req_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_err, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_chain, res_ready, alu_result,
        output req_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/calc_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_op_sequencer
//  Description : Runs one calculator operation at a time. Non-divide opcodes
//                are issued to the external ALU and sampled after ALU_LAT
//                cycles; DIV_OP runs on an internal restoring divider
//                (one quotient bit per cycle) with divide-by-zero trapped.
//                Optional feature macro: CALC_SEQ_CHAIN_EN (reuse the last
//                good result as operand A when req_chain is set).
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_op_sequencer #(
    parameter int         WIDTH   = 16,
    parameter int         ALU_LAT = 1,
    parameter logic [3:0] DIV_OP  = 4'h3
) (
    input  wire logic         clk,
    input  wire logic         reset,
    calc_op_sequencer_if.slave bus
);

    localparam int CNT_MAX = (WIDTH > ALU_LAT) ? WIDTH : ALU_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] CNT_ALU_INIT = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_DIV_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ALU_WAIT = 2'd1;
    localparam logic [1:0] ST_DIV_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] alu_a_q,    alu_a_d;
    logic [WIDTH-1:0] alu_b_q,    alu_b_d;
    logic [3:0]       alu_op_q,   alu_op_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_err_q,  res_err_d;
    logic [WIDTH-1:0] quo_q,      quo_d;
    // The partial remainder is always below the divisor, so WIDTH bits hold
    // it; the extra (WIDTH+1)th bit only exists inside the trial value.
    logic [WIDTH-1:0] rem_q,      rem_d;
    logic [WIDTH-1:0] div_b_q,    div_b_d;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_quo_next;
    logic [WIDTH-1:0] div_rem_next;

`ifdef CALC_SEQ_CHAIN_EN
    logic [WIDTH-1:0] last_result_q, last_result_d;

    // Operand A comes from the last good result when chaining is requested
    always_comb begin
        op_a = bus.req_chain ? last_result_q : bus.req_a;
    end

    // Capture every error-free result at the moment the consumer takes it
    always_comb begin
        last_result_d = last_result_q;
        if ((state_q == ST_DONE) && bus.res_ready && !res_err_q) begin
            last_result_d = res_data_q;
        end
    end

    // Last-result register
    always_ff @(posedge clk) begin
        if (reset) begin
            last_result_q <= '0;
        end else begin
            last_result_q <= last_result_d;
        end
    end
`else
    logic unused_req_chain;
    assign unused_req_chain = bus.req_chain;

    // Without chaining operand A is always the requested one
    always_comb begin
        op_a = bus.req_a;
    end
`endif

    // One restoring-division step; a set sign bit on the difference means T < B
    always_comb begin
        div_trial    = {rem_q, quo_q[WIDTH-1]};
        div_diff     = div_trial - {1'b0, div_b_q};
        div_ge       = ~div_diff[WIDTH];
        div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
        div_quo_next = {quo_q[WIDTH-2:0], div_ge};
    end

    // State and datapath registers; reset overrides everything, even mid-divide
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            div_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            div_b_q    <= div_b_d;
        end
    end

    // Next-state and datapath update for the four-state sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        div_b_d    = div_b_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_op == DIV_OP) begin
                        if (bus.req_b == '0) begin
                            // Trap divide-by-zero without entering the divider
                            res_data_d = '0;
                            res_err_d  = 1'b1;
                            state_d    = ST_DONE;
                        end else begin
                            quo_d   = op_a;
                            rem_d   = '0;
                            div_b_d = bus.req_b;
                            cnt_d   = CNT_DIV_INIT;
                            state_d = ST_DIV_RUN;
                        end
                    end else begin
                        alu_a_d  = op_a;
                        alu_b_d  = bus.req_b;
                        alu_op_d = bus.req_op;
                        cnt_d    = CNT_ALU_INIT;
                        state_d  = ST_ALU_WAIT;
                    end
                end
            end

            ST_ALU_WAIT: begin
                if (cnt_q == '0) begin
                    res_data_d = bus.alu_result;
                    res_err_d  = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_DIV_RUN: begin
                quo_d = div_quo_next;
                rem_d = div_rem_next;
                if (cnt_q == '0) begin
                    res_data_d = div_quo_next;
                    res_err_d  = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_DONE: begin
                // Returning to IDLE costs a cycle, so no accept coincides
                // with the result handshake
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags decode from state; data outputs come straight from flops
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.res_valid = (state_q == ST_DONE);
        bus.busy      = (state_q != ST_IDLE);
        bus.alu_a     = alu_a_q;
        bus.alu_b     = alu_b_q;
        bus.alu_op    = alu_op_q;
        bus.res_data  = res_data_q;
        bus.res_err   = res_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_op_sequencer
//  Description : Self-checking bench for calc_op_sequencer with a behavioural
//                ALU and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_op_sequencer;

    localparam int         WIDTH   = 16;
    localparam int         ALU_LAT = 1;
    localparam logic [3:0] DIV_OP  = 4'h3;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [WIDTH-1:0] last_model = '0;

    calc_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

    calc_op_sequencer #(
        .WIDTH   (WIDTH),
        .ALU_LAT (ALU_LAT),
        .DIV_OP  (DIV_OP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [3:0] op);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h4:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [3:0] op, input logic chain, output int n);
        logic [WIDTH-1:0] ea;
        exp_t e;
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        bus.req_chain = chain;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        bus.req_valid = 1'b0;
        bus.req_chain = 1'b0;
        ea = a;
`ifdef CALC_SEQ_CHAIN_EN
        if (chain) ea = last_model;
`endif
        if (op == DIV_OP) begin
            if (b == '0) begin
                e.data = '0; e.err = 1'b1; e.lat = 1;
            end else begin
                e.data = ea / b; e.err = 1'b0; e.lat = WIDTH + 1;
            end
        end else begin
            e.data = alu_f(ea, b, op); e.err = 1'b0; e.lat = ALU_LAT + 1;
            chk("alu_a", 32'(bus.alu_a), 32'(ea));
            chk("alu_b", 32'(bus.alu_b), 32'(b));
            chk("alu_op", 32'(bus.alu_op), 32'(op));
        end
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        sb.push_back(e);
    endtask

    task automatic collect(input int n, input int hold);
        exp_t e;
        bit seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen || sb.size() == 0) begin
            chk("res_valid_timeout", 32'(seen), 32'd1);
            chk("sb_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("latency", 32'(cyc - n + 1), 32'(e.lat));
        chk("res_data", 32'(bus.res_data), 32'(e.data));
        chk("res_err", 32'(bus.res_err), 32'(e.err));
        for (int h = 0; h < hold; h++) begin
            bus.req_a     = 16'h1234;
            bus.req_b     = 16'h0001;
            bus.req_op    = 4'h0;
            bus.req_valid = 1'b1;
            @(negedge clk);
            chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_res_data", 32'(bus.res_data), 32'(e.data));
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        if (!e.err) last_model = e.data;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        chk("idle_after_hs", 32'(bus.req_ready), 32'd1);
        chk("busy_after_hs", 32'(bus.busy), 32'd0);
        chk("res_valid_drop", 32'(bus.res_valid), 32'd0);
        chk("res_data_kept", 32'(bus.res_data), 32'(e.data));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_data"},  32'(bus.res_data), 32'd0);
        chk({tag, "_res_err"},   32'(bus.res_err), 32'd0);
        chk({tag, "_alu_a"},     32'(bus.alu_a), 32'd0);
        chk({tag, "_alu_b"},     32'(bus.alu_b), 32'd0);
        chk({tag, "_alu_op"},    32'(bus.alu_op), 32'd0);
        chk({tag, "_busy"},      32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.req_chain = 1'b0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset = 1'b0;

        issue(16'd100, 16'd23, 4'h0, 1'b0, n);     collect(n, 0);
        issue(16'd500, 16'd600, 4'h1, 1'b0, n);    collect(n, 0);
        issue(16'hF0F0, 16'h0FF0, 4'h2, 1'b0, n);  collect(n, 0);
        issue(16'h00FF, 16'h0F0F, 4'h5, 1'b0, n);  collect(n, 0);
        issue(16'hFFFF, 16'h0002, 4'h0, 1'b0, n);  collect(n, 0);
        issue(16'd1000, 16'd7, DIV_OP, 1'b0, n);   collect(n, 0);
        issue(16'd5, 16'd0, DIV_OP, 1'b0, n);      collect(n, 0);
        issue(16'd3, 16'd9, DIV_OP, 1'b0, n);      collect(n, 0);
        issue(16'hFFFF, 16'hFFFF, DIV_OP, 1'b0, n); collect(n, 0);
        issue(16'd65535, 16'd1, DIV_OP, 1'b0, n);  collect(n, 10);

`ifdef CALC_SEQ_CHAIN_EN
        issue(16'd10, 16'd5, 4'h0, 1'b0, n);       collect(n, 0);
        issue(16'd0, 16'd3, DIV_OP, 1'b1, n);      collect(n, 0);
`else
        issue(16'd77, 16'd7, DIV_OP, 1'b1, n);     collect(n, 0);
`endif

        // Reset in the middle of a long divide
        issue(16'd65535, 16'd1, DIV_OP, 1'b0, n);
        void'(sb.pop_back());
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_state("midrst");

        issue(16'd9, 16'd3, DIV_OP, 1'b0, n);      collect(n, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
